// File: rtl/red_pitaya_exp_trig_pkg.sv
// rtl/red_pitaya_exp_trig_pkg.sv - shared register map, init length and state encoding
package red_pitaya_exp_trig_pkg;

    localparam logic [19:0] REG_EN       = 20'h00;
    localparam logic [19:0] REG_RISE     = 20'h04;
    localparam logic [19:0] REG_FALL     = 20'h08;
    localparam logic [19:0] REG_DEB      = 20'h0C;
    localparam logic [19:0] REG_STABLE   = 20'h10;
    localparam logic [19:0] REG_FLAGS    = 20'h14;
    localparam logic [19:0] REG_SYNC     = 20'h18;
    localparam logic [19:0] REG_CNT_BASE = 20'h40;

    localparam int INIT_LEN = 3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/red_pitaya_exp_trig_chan.sv
// rtl/red_pitaya_exp_trig_chan.sv - one pin: synchroniser, debounce, edge detect, counter, flag
module red_pitaya_exp_trig_chan #(
    parameter int DEB_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pin,
    input  logic             run,
    input  logic             init_load,
    input  logic             en,
    input  logic             rise_en,
    input  logic             fall_en,
    input  logic [DEB_W-1:0] deb_len,
    input  logic             flag_clr,
    input  logic             cnt_clr,
    output logic             sync,
    output logic             stable,
    output logic             ev,
    output logic             trig,
    output logic             flag,
    output logic [CNT_W-1:0] cnt
);

    logic             meta;
    logic             prev;
    logic [DEB_W-1:0] deb_cnt;

    // prev lags stable by one cycle, so an edge is seen exactly once after stable moves
    assign ev = run & en & ((rise_en & stable & ~prev) | (fall_en & ~stable & prev));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            stable  <= 1'b0;
            prev    <= 1'b0;
            deb_cnt <= '0;
            trig    <= 1'b0;
            flag    <= 1'b0;
            cnt     <= '0;
        end else begin
            meta <= pin;
            sync <= meta;
            if (init_load) begin
                stable  <= sync;
                prev    <= sync;
                deb_cnt <= '0;
            end else if (run) begin
                prev <= stable;
                if (sync == stable) begin
                    deb_cnt <= '0;
                end else if (deb_cnt >= deb_len) begin
                    stable  <= sync;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
            trig <= ev;
            if (ev) begin
                flag <= 1'b1;
            end else if (flag_clr) begin
                flag <= 1'b0;
            end
            if (cnt_clr) begin
                cnt <= {{(CNT_W-1){1'b0}}, ev};
            end else if (ev && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/red_pitaya_exp_trig_rx.sv
// rtl/red_pitaya_exp_trig_rx.sv - expansion connector trigger receiver with bus registers
module red_pitaya_exp_trig_rx
    import red_pitaya_exp_trig_pkg::*;
#(
    parameter int DWE   = 8,
    parameter int DEB_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DWE-1:0]   exp_p_dat_i,
    input  logic [DWE-1:0]   exp_n_dat_i,
    output logic [2*DWE-1:0] trig_o,
    output logic             trig_any_o,
    input  logic [31:0]      sys_addr,
    input  logic [31:0]      sys_wdata,
    input  logic [3:0]       sys_sel,
    input  logic             sys_wen,
    input  logic             sys_ren,
    output logic [31:0]      sys_rdata,
    output logic             sys_err,
    output logic             sys_ack
);

    localparam int NCH = 2 * DWE;

    state_t           state_q, state_d;
    logic [1:0]       init_cnt_q;
    logic             init_load, run;
    logic [NCH-1:0]   en_q, rise_en_q, fall_en_q;
    logic [DEB_W-1:0] deb_len_q;
    logic [NCH-1:0]   pins, sync, stable, ev, flag, flag_clr, cnt_clr;
    logic [CNT_W-1:0] cnt [NCH];
    logic [19:0]      addr, cnt_off;
    logic             cnt_hit;
    logic [31:0]      rd_val;
    logic             unused_ok;

    assign unused_ok = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata};
    assign sys_err   = 1'b0;
    assign pins      = {exp_n_dat_i, exp_p_dat_i};
    assign addr      = sys_addr[19:0];
    assign cnt_off   = addr - REG_CNT_BASE;
    assign cnt_hit   = (addr >= REG_CNT_BASE) && (cnt_off < 20'(4 * NCH)) && (addr[1:0] == 2'b00);
    assign init_load = (state_q == ST_INIT) && (init_cnt_q == 2'(INIT_LEN - 1));
    assign run       = (state_q == ST_RUN);
    assign flag_clr  = {NCH{sys_wen && (addr == REG_FLAGS)}} & sys_wdata[NCH-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_load) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_INIT) && !init_load) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign cnt_clr[i] = sys_wen && cnt_hit && (cnt_off[19:2] == 18'(i));

        red_pitaya_exp_trig_chan #(
            .DEB_W (DEB_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .pin       (pins[i]),
            .run       (run),
            .init_load (init_load),
            .en        (en_q[i]),
            .rise_en   (rise_en_q[i]),
            .fall_en   (fall_en_q[i]),
            .deb_len   (deb_len_q),
            .flag_clr  (flag_clr[i]),
            .cnt_clr   (cnt_clr[i]),
            .sync      (sync[i]),
            .stable    (stable[i]),
            .ev        (ev[i]),
            .trig      (trig_o[i]),
            .flag      (flag[i]),
            .cnt       (cnt[i])
        );
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            REG_EN:     rd_val[NCH-1:0]   = en_q;
            REG_RISE:   rd_val[NCH-1:0]   = rise_en_q;
            REG_FALL:   rd_val[NCH-1:0]   = fall_en_q;
            REG_DEB:    rd_val[DEB_W-1:0] = deb_len_q;
            REG_STABLE: rd_val[NCH-1:0]   = stable;
            REG_FLAGS:  rd_val[NCH-1:0]   = flag;
            REG_SYNC:   rd_val[NCH-1:0]   = sync;
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (cnt_hit && (cnt_off[19:2] == 18'(i))) rd_val[CNT_W-1:0] = cnt[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            deb_len_q  <= '0;
            trig_any_o <= 1'b0;
            sys_ack    <= 1'b0;
            sys_rdata  <= '0;
        end else begin
            trig_any_o <= |ev;
            sys_ack    <= sys_wen | sys_ren;
            sys_rdata  <= sys_ren ? rd_val : '0;
            if (sys_wen) begin
                case (addr)
                    REG_EN:   en_q      <= sys_wdata[NCH-1:0];
                    REG_RISE: rise_en_q <= sys_wdata[NCH-1:0];
                    REG_FALL: fall_en_q <= sys_wdata[NCH-1:0];
                    REG_DEB:  deb_len_q <= sys_wdata[DEB_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_exp_trig_rx.sv
// tb/tb_red_pitaya_exp_trig_rx.sv - scoreboard bench for the expansion trigger receiver
module tb_red_pitaya_exp_trig_rx;
    import red_pitaya_exp_trig_pkg::*;

    localparam int DWE = 8;
    localparam int NCH = 2 * DWE;

    typedef struct {int cyc; int ch;} exp_trig_t;
    typedef struct {bit is_rd; logic [31:0] data;} exp_bus_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DWE-1:0] exp_p = '0;
    logic [DWE-1:0] exp_n = '0;
    logic [NCH-1:0] trig_o;
    logic           trig_any_o;
    logic [31:0]    sys_addr = '0;
    logic [31:0]    sys_wdata = '0;
    logic [3:0]     sys_sel = 4'hF;
    logic           sys_wen = 1'b0;
    logic           sys_ren = 1'b0;
    logic [31:0]    sys_rdata;
    logic           sys_err;
    logic           sys_ack;

    int        cyc = 0;
    int        n_tests = 0;
    int        n_fail = 0;
    bit        sb_off = 1'b0;
    exp_trig_t trig_q[$];
    exp_bus_t  bus_q[$];
    exp_trig_t m_tr;
    exp_bus_t  m_bus;

    red_pitaya_exp_trig_rx #(.DWE(DWE), .DEB_W(16), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exp_p_dat_i (exp_p),
        .exp_n_dat_i (exp_n),
        .trig_o      (trig_o),
        .trig_any_o  (trig_any_o),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_sel     (sys_sel),
        .sys_wen     (sys_wen),
        .sys_ren     (sys_ren),
        .sys_rdata   (sys_rdata),
        .sys_err     (sys_err),
        .sys_ack     (sys_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back('{1'b0, 32'h0});
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
        check("wr_ack", 32'(sys_ack), 32'd1);
        check("wr_err", 32'(sys_err), 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
        bus_q.push_back('{1'b1, exp});
        sys_addr = a; sys_ren = 1'b1;
        @(negedge clk);
        sys_ren = 1'b0;
        check("rd_ack", 32'(sys_ack), 32'd1);
        check("rd_err", 32'(sys_err), 32'd0);
    endtask

    // a pin change made at this falling edge appears on trig_o deb+4 sampled cycles later
    task automatic expect_trig(input int ch, input int deb);
        trig_q.push_back('{cyc + 4 + deb, ch});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sys_ack) begin
                if (bus_q.size() == 0) begin
                    check("ack_unexpected", 32'(sys_ack), 32'd0);
                end else begin
                    m_bus = bus_q.pop_front();
                    if (m_bus.is_rd) check($sformatf("rdata@%0h", sys_addr), sys_rdata, m_bus.data);
                end
            end
            if (!sb_off) begin
                while (trig_q.size() > 0 && trig_q[0].cyc < cyc) begin
                    m_tr = trig_q.pop_front();
                    check($sformatf("trig_missed_ch%0d", m_tr.ch), 32'(cyc), 32'(m_tr.cyc));
                end
                if (trig_o != '0) begin
                    if (trig_q.size() == 0) begin
                        check("trig_extra", 32'(trig_o), 32'd0);
                    end else begin
                        m_tr = trig_q.pop_front();
                        check("trig_cycle", 32'(cyc), 32'(m_tr.cyc));
                        check("trig_chan", 32'(trig_o), 32'd1 << m_tr.ch);
                    end
                end
                if (trig_o != '0 || trig_any_o) check("trig_any", 32'(trig_any_o), 32'(|trig_o));
            end
        end
    end

    initial begin
        exp_p[0] = 1'b1;
        tick(4);
        check("rst_trig", 32'(trig_o), 32'd0);
        check("rst_trig_any", 32'(trig_any_o), 32'd0);
        check("rst_ack", 32'(sys_ack), 32'd0);
        check("rst_err", 32'(sys_err), 32'd0);
        check("rst_rdata", sys_rdata, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_INIT));
        rst = 1'b0;
        tick(6);

        // P[0] held high through reset must not fire once enabled
        bus_write(32'h00, 32'hFFFF);
        bus_write(32'h04, 32'hFFFF);
        bus_write(32'h08, 32'h0);
        bus_write(32'h0C, 32'h0);
        tick(10);
        bus_read(32'h10, 32'h0001);
        bus_read(32'h40, 32'h0);
        bus_read(32'h18, 32'h0001);

        // deb_len=0 rising edge on P[2]
        exp_p[2] = 1'b1; expect_trig(2, 0);
        tick(10);
        bus_read(32'h48, 32'd1);
        bus_read(32'h14, 32'h0004);
        bus_read(32'h10, 32'h0005);

        // deb_len=5: 4-cycle glitch on N[1] is filtered, steady level fires once
        bus_write(32'h0C, 32'd5);
        exp_n[1] = 1'b1; tick(4); exp_n[1] = 1'b0;
        tick(12);
        exp_n[1] = 1'b1; expect_trig(DWE + 1, 5);
        tick(20);
        bus_read(32'h64, 32'd1);
        bus_read(32'h18, 32'h0205);

        // fall-only on P[3]
        bus_write(32'h0C, 32'd0);
        bus_write(32'h04, 32'hFFF7);
        bus_write(32'h08, 32'h0008);
        exp_p[3] = 1'b1; tick(8);
        exp_p[3] = 1'b0; expect_trig(3, 0);
        tick(10);
        bus_read(32'h4C, 32'd1);

        // W1C coincident with a new event: set wins
        bus_write(32'h14, 32'hFFFF);
        bus_read(32'h14, 32'h0);
        bus_write(32'h08, 32'h000C);
        exp_p[2] = 1'b0; expect_trig(2, 0);
        tick(3);
        bus_write(32'h14, 32'h0004);
        tick(4);
        bus_read(32'h14, 32'h0004);
        bus_read(32'h48, 32'd2);

        // counter clear coincident with an event reads back 1
        exp_p[2] = 1'b1; expect_trig(2, 0);
        tick(3);
        bus_write(32'h48, 32'h0);
        tick(5);
        bus_read(32'h48, 32'd1);

        // saturate counter 5 with an event every cycle
        bus_write(32'h00, 32'h0020);
        bus_write(32'h04, 32'hFFFF);
        bus_write(32'h08, 32'hFFFF);
        sb_off = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            exp_p[5] = ~exp_p[5];
            @(negedge clk);
        end
        tick(10);
        sb_off = 1'b0;
        bus_read(32'h54, 32'hFFFF);
        bus_write(32'h54, 32'h0);
        bus_read(32'h54, 32'h0);

        // register width masking and unmapped window
        bus_write(32'h00, 32'h1234ABCD);
        bus_read(32'h00, 32'h0000ABCD);
        bus_write(32'h0C, 32'hFFFF0007);
        bus_read(32'h0C, 32'h0007);
        bus_write(32'h7FC, 32'hDEADBEEF);
        bus_read(32'h7FC, 32'h0);
        tick(2);
        check("ack_drop", 32'(sys_ack), 32'd0);

        // reset in the middle of a long debounce
        bus_write(32'h00, 32'hFFFF);
        bus_write(32'h0C, 32'd100);
        exp_p[4] = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(2);
        check("midrst_state", 32'(dut.state_q), 32'(ST_INIT));
        check("midrst_trig", 32'(trig_o), 32'd0);
        rst = 1'b0;
        tick(6);
        bus_read(32'h48, 32'h0);
        bus_read(32'h4C, 32'h0);
        bus_read(32'h64, 32'h0);
        bus_read(32'h14, 32'h0);
        bus_read(32'h00, 32'h0);
        bus_read(32'h0C, 32'h0);
        bus_read(32'h10, 32'h0215);
        tick(4);

        check("trig_queue_empty", 32'(trig_q.size()), 32'd0);
        check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/red_pitaya_exp_trig_rx.md
Name: red_pitaya_exp_trig_rx

Overview:
- Receive side of the expansion connector. Samples exp_p_dat_i and exp_n_dat_i pins, synchronises and debounces them, and detects selectable edges.
- Emits one-cycle trigger pulses towards the DSP/ASG trigger muxes, with per-pin event counters and sticky flags.
- Sits beside the housekeeping block on the same system-bus decode, in its own address window.

Parameters:
- DWE, 8: pins per connector side; both sides together give 2*DWE channels, with channel i<DWE = P[i] and channel DWE+i = N[i].
- DEB_W, 16: debounce-length register and counter width.
- CNT_W, 16: per-channel event counter width (saturating).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- exp_p_dat_i  in  DWE  raw P-side pin levels (asynchronous)
- exp_n_dat_i  in  DWE  raw N-side pin levels (asynchronous)
- trig_o  out  2*DWE  one-cycle edge pulses per channel
- trig_any_o  out  1  OR of trig_o, registered together with it
- sys_addr  in  32  bus address
- sys_wdata  in  32  bus write data
- sys_sel  in  4  byte select (ignored; full-word writes only)
- sys_wen  in  1  write enable
- sys_ren  in  1  read enable
- sys_rdata  out  32  read data
- sys_err  out  1  always 0
- sys_ack  out  1  acknowledge

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - Outputs: trig_o=0, trig_any_o=0, sys_ack=0, sys_err=0, sys_rdata=0.
  - Registers: all enables 0, deb_len=0, flags=0, counters=0, state=INIT.
- Synchroniser: per channel, 2-flop chain; sync = second flop.
- Top FSM, INIT -> RUN:
  - INIT lasts 3 cycles after reset release. On the last INIT cycle, stable[i] <= sync[i]; no events are generated.
  - RUN is permanent until reset. Reset mid-operation returns to INIT and clears every counter and flag.
- Debounce, RUN only, per channel:
  - sync==stable: cnt <= 0.
  - Otherwise, if cnt >= deb_len: stable <= sync, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Result: stable changes after sync has differed for deb_len+1 consecutive cycles. Using >= makes lowering deb_len mid-count take effect immediately and never wraps.
- Edge detect:
  - rise[i] = stable rises & rise_en[i] & en[i]; fall[i] likewise with fall_en[i].
  - trig_o[i] <= rise[i] | fall[i], a registered one-cycle pulse.
  - Latency: pin change first sampled at edge k gives trig_o high during cycle k+3+deb_len.
- Sticky flags: set on trig. A write-1-to-clear on the same cycle as a new event leaves the bit set (set wins).
- Counters:
  - Increment on trig and saturate at 2^CNT_W-1.
  - Any write to a counter clears it. A clear coinciding with an event yields 1.
- Bus:
  - sys_ack <= sys_wen|sys_ren one cycle after the request, for every address (unmapped reads return 0).
  - sys_rdata is registered in the same cycle as ack.
  - Address decode uses sys_addr[19:0].
- Register map, in the shared package:
  - 0x00 en[2*DWE-1:0] RW
  - 0x04 rise_en RW
  - 0x08 fall_en RW
  - 0x0C deb_len[DEB_W-1:0] RW
  - 0x10 stable levels RO
  - 0x14 sticky flags RO/W1C
  - 0x18 raw sync levels RO
  - 0x40+4*i counter i RO, write-clears, for i=0..2*DWE-1
- Widths: unused upper read bits are 0; write data above the field width is ignored.

Decomposition:
- Package red_pitaya_exp_trig_pkg: register offset constants, INIT length (3), state encoding {INIT, RUN}.
- Sub-module red_pitaya_exp_trig_chan: one per channel. Contains the synchroniser, debounce counter, stable level, edge detect, counter and flag.
- Top level: FSM, bus decode, instance array.

Test Plan:
- Reset with P[0] held high, en=all, rise_en=all -> no trig_o pulse after INIT; 0x10 reads bit0=1; counter 0 reads 0.
- deb_len=0, P[2] 0->1 first sampled at edge k -> trig_o[2] high exactly in cycle k+3 for 1 cycle; trig_any_o same cycle; counter 2 = 1; flag bit2 = 1.
- deb_len=5, N[1] glitch of 4 cycles then steady 20 cycles -> single pulse at channel DWE+1, 9 cycles after the steady level starts; glitch produces nothing.
- fall_en only on P[3]; toggle 0->1->0 -> exactly one pulse, on the falling edge; rise_en=0 suppresses the rising one.
- W1C to 0x14 bit2 coincident with a new P[2] event -> flag stays 1. Counter write coincident with an event -> reads 1. Forcing a counter to max by 2^CNT_W+3 events -> reads 0xFFFF.
- Reads/writes at 0x00, 0x0C, 0x7FC (unmapped) -> ack 1 cycle after the request each time, err=0, unmapped reads 0; assert rst_i mid-debounce -> state INIT, all counters and flags 0.
